pc_sequencer: RTL and testbench

Program-counter sequencer sitting directly downstream of the halt controller. It consumes the halt controller's H output and freezes the PC while H=1. Each one-cycle drop of H, one per falling edge of the step/enable button, lets the PC advance exactly once. While running, it selects the next PC from increment, jump, conditional branch, call or return, and keeps a small hardware return-address stack.

---
 rtl/pc_sequencer_if.sv | 32 +++
 rtl/pc_sequencer.sv | 111 +++++++++++
 tb/tb_pc_sequencer.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if
//   Control/status bundle between the halt controller side (master) and
//   the program-counter sequencer (slave).
//   master drives : H, JUMP, BRANCH, COND, CALL, RET, TARGET
//   slave drives  : PC, FETCH_VALID, LEVEL, STK_OVF, STK_UNF
interface pc_sequencer_if #(
  parameter int AW  = 8,
  parameter int SPW = 3
);
  logic          H;
  logic          JUMP;
  logic          BRANCH;
  logic          COND;
  logic          CALL;
  logic          RET;
  logic [AW-1:0] TARGET;
  logic [AW-1:0] PC;
  logic          FETCH_VALID;
  logic [SPW-1:0] LEVEL;
  logic          STK_OVF;
  logic          STK_UNF;

  modport master (
    output H, JUMP, BRANCH, COND, CALL, RET, TARGET,
    input  PC, FETCH_VALID, LEVEL, STK_OVF, STK_UNF
  );

  modport slave (
    input  H, JUMP, BRANCH, COND, CALL, RET, TARGET,
    output PC, FETCH_VALID, LEVEL, STK_OVF, STK_UNF
  );
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer
//   Program-counter sequencer gated by the halt controller's H signal.
//   While H=1 all state is frozen; each posedge with H=0 performs exactly
//   one action by priority RET > CALL > JUMP > taken BRANCH > increment,
//   and keeps a small return-address stack.
// Ports
//   CLK   : clock, all state updates on posedge
//   RESET : synchronous, active-low reset (overrides H and controls)
//   bus   : pc_sequencer_if.slave -- controls in; PC, FETCH_VALID, LEVEL,
//           STK_OVF, STK_UNF out (all registered)
module pc_sequencer #(
  parameter int AW          = 8,
  parameter int STACK_DEPTH = 4,
  parameter int SPW         = 3
) (
  input  logic               CLK,
  input  logic               RESET,
  pc_sequencer_if.slave      bus
);

  logic [AW-1:0]  pc_q, pc_d;
  logic [SPW-1:0] level_q, level_d;
  logic           fv_q, fv_d;
  logic           ovf_q, ovf_d;
  logic           unf_q, unf_d;
  logic [AW-1:0]  stack_q [STACK_DEPTH];

  logic [AW-1:0]  pc_inc_s;
  logic [AW-1:0]  top_s;
  logic           push_en_s;

  // Incremented PC wraps naturally modulo 2^AW; also used as return address.
  assign pc_inc_s = pc_q + AW'(1);

  // Top-of-stack select: one-hot match on LEVEL-1, OR-combined.
  always_comb begin
    top_s = '0;
    for (int i = 0; i < STACK_DEPTH; i++) begin
      top_s = top_s | (stack_q[i] & {AW{level_q == SPW'(i + 1)}});
    end
  end

  // Next-state selection for PC, stack level, flags and fetch strobe.
  always_comb begin
    pc_d      = pc_q;
    level_d   = level_q;
    ovf_d     = ovf_q;
    unf_d     = unf_q;
    fv_d      = 1'b0;
    push_en_s = 1'b0;
    if (bus.H) begin
      fv_d = 1'b0;
    end else begin
      fv_d = 1'b1;
      if (bus.RET) begin
        if (level_q != SPW'(0)) begin
          pc_d    = top_s;
          level_d = level_q - SPW'(1);
        end else begin
          pc_d  = pc_inc_s;
          unf_d = 1'b1;
        end
      end else if (bus.CALL) begin
        pc_d = bus.TARGET;
        if (level_q < SPW'(STACK_DEPTH)) begin
          push_en_s = 1'b1;
          level_d   = level_q + SPW'(1);
        end else begin
          ovf_d = 1'b1;
        end
      end else if (bus.JUMP || (bus.BRANCH && bus.COND)) begin
        pc_d = bus.TARGET;
      end else begin
        pc_d = pc_inc_s;
      end
    end
  end

  // Architectural state register with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      pc_q    <= '0;
      level_q <= '0;
      fv_q    <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      level_q <= level_d;
      fv_q    <= fv_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Return-address storage; contents are don't-care after reset, so no reset.
  always_ff @(posedge CLK) begin
    for (int i = 0; i < STACK_DEPTH; i++) begin
      if (RESET && push_en_s && (level_q == SPW'(i))) begin
        stack_q[i] <= pc_inc_s;
      end
    end
  end

  assign bus.PC          = pc_q;
  assign bus.FETCH_VALID = fv_q;
  assign bus.LEVEL       = level_q;
  assign bus.STK_OVF     = ovf_q;
  assign bus.STK_UNF     = unf_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer
//   Directed, table-driven bench for pc_sequencer plus hand-written
//   sequences for hold, single-step and mid-chain reset.
module tb_pc_sequencer;

  localparam int AW  = 8;
  localparam int SD  = 4;
  localparam int SPW = 3;

  typedef struct {
    logic [5:0]     ctrl;   // {H, JUMP, BRANCH, COND, CALL, RET}
    logic [AW-1:0]  tgt;
    logic [AW-1:0]  e_pc;
    logic           e_fv;
    logic [SPW-1:0] e_lvl;
    logic           e_ovf;
    logic           e_unf;
  } vec_t;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;
  vec_t vecs[$];

  pc_sequencer_if #(.AW(AW), .SPW(SPW)) bus ();

  pc_sequencer #(.AW(AW), .STACK_DEPTH(SD), .SPW(SPW)) dut (
    .CLK   (clk),
    .RESET (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic [5:0] c, input logic [AW-1:0] t);
    {bus.H, bus.JUMP, bus.BRANCH, bus.COND, bus.CALL, bus.RET} = c;
    bus.TARGET = t;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cmp(input string name, input string fld, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s %s: got %0h expected %0h", name, fld, act, exp);
    end
  endtask

  task automatic check(input string name, input logic [AW-1:0] pc, input logic fv,
                       input logic [SPW-1:0] lvl, input logic ovf, input logic unf);
    cmp(name, "PC", int'(bus.PC), int'(pc));
    cmp(name, "FETCH_VALID", int'(bus.FETCH_VALID), int'(fv));
    cmp(name, "LEVEL", int'(bus.LEVEL), int'(lvl));
    cmp(name, "STK_OVF", int'(bus.STK_OVF), int'(ovf));
    cmp(name, "STK_UNF", int'(bus.STK_UNF), int'(unf));
  endtask

  task automatic add(input logic [5:0] c, input logic [AW-1:0] t, input logic [AW-1:0] pc,
                     input logic fv, input logic [SPW-1:0] lvl, input logic ovf, input logic unf);
    vec_t v;
    v.ctrl = c; v.tgt = t; v.e_pc = pc; v.e_fv = fv;
    v.e_lvl = lvl; v.e_ovf = ovf; v.e_unf = unf;
    vecs.push_back(v);
  endtask

  initial begin
    tests = 0;
    fails = 0;

    // ctrl bits: H J B C CALL RET
    // free run from reset
    add(6'b000000, 8'h00, 8'h01, 1'b1, 3'd0, 1'b0, 1'b0);
    add(6'b000000, 8'h00, 8'h02, 1'b1, 3'd0, 1'b0, 1'b0);
    add(6'b000000, 8'h00, 8'h03, 1'b1, 3'd0, 1'b0, 1'b0);
    add(6'b000000, 8'h00, 8'h04, 1'b1, 3'd0, 1'b0, 1'b0);
    add(6'b000000, 8'h00, 8'h05, 1'b1, 3'd0, 1'b0, 1'b0);
    // halted jump ignored, then single step takes it
    add(6'b110000, 8'h40, 8'h05, 1'b0, 3'd0, 1'b0, 1'b0);
    add(6'b110000, 8'h40, 8'h05, 1'b0, 3'd0, 1'b0, 1'b0);
    add(6'b010000, 8'h40, 8'h40, 1'b1, 3'd0, 1'b0, 1'b0);
    add(6'b110000, 8'h40, 8'h40, 1'b0, 3'd0, 1'b0, 1'b0);
    // call / return
    add(6'b010000, 8'h10, 8'h10, 1'b1, 3'd0, 1'b0, 1'b0);
    add(6'b000010, 8'h80, 8'h80, 1'b1, 3'd1, 1'b0, 1'b0);
    add(6'b000000, 8'h00, 8'h81, 1'b1, 3'd1, 1'b0, 1'b0);
    add(6'b000000, 8'h00, 8'h82, 1'b1, 3'd1, 1'b0, 1'b0);
    add(6'b000001, 8'h00, 8'h11, 1'b1, 3'd0, 1'b0, 1'b0);
    // branch not taken / taken
    add(6'b001000, 8'h33, 8'h12, 1'b1, 3'd0, 1'b0, 1'b0);
    add(6'b001100, 8'h33, 8'h33, 1'b1, 3'd0, 1'b0, 1'b0);
    // priority
    add(6'b000010, 8'h50, 8'h50, 1'b1, 3'd1, 1'b0, 1'b0);
    add(6'b010011, 8'h70, 8'h34, 1'b1, 3'd0, 1'b0, 1'b0);
    add(6'b011000, 8'h20, 8'h20, 1'b1, 3'd0, 1'b0, 1'b0);
    add(6'b010010, 8'h90, 8'h90, 1'b1, 3'd1, 1'b0, 1'b0);
    add(6'b011100, 8'hA0, 8'hA0, 1'b1, 3'd1, 1'b0, 1'b0);
    add(6'b000001, 8'h00, 8'h21, 1'b1, 3'd0, 1'b0, 1'b0);
    // wrap, including pushed return address
    add(6'b010000, 8'hFF, 8'hFF, 1'b1, 3'd0, 1'b0, 1'b0);
    add(6'b000000, 8'h00, 8'h00, 1'b1, 3'd0, 1'b0, 1'b0);
    add(6'b010000, 8'hFE, 8'hFE, 1'b1, 3'd0, 1'b0, 1'b0);
    add(6'b000000, 8'h00, 8'hFF, 1'b1, 3'd0, 1'b0, 1'b0);
    add(6'b000010, 8'h05, 8'h05, 1'b1, 3'd1, 1'b0, 1'b0);
    add(6'b000001, 8'h00, 8'h00, 1'b1, 3'd0, 1'b0, 1'b0);
    // nested calls to overflow, LIFO returns, underflow
    add(6'b010000, 8'h10, 8'h10, 1'b1, 3'd0, 1'b0, 1'b0);
    add(6'b000010, 8'hA1, 8'hA1, 1'b1, 3'd1, 1'b0, 1'b0);
    add(6'b000010, 8'hB2, 8'hB2, 1'b1, 3'd2, 1'b0, 1'b0);
    add(6'b000010, 8'hC3, 8'hC3, 1'b1, 3'd3, 1'b0, 1'b0);
    add(6'b000010, 8'hD4, 8'hD4, 1'b1, 3'd4, 1'b0, 1'b0);
    add(6'b000010, 8'hE5, 8'hE5, 1'b1, 3'd4, 1'b1, 1'b0);
    add(6'b000001, 8'h00, 8'hC4, 1'b1, 3'd3, 1'b1, 1'b0);
    add(6'b000001, 8'h00, 8'hB3, 1'b1, 3'd2, 1'b1, 1'b0);
    add(6'b000001, 8'h00, 8'hA2, 1'b1, 3'd1, 1'b1, 1'b0);
    add(6'b000001, 8'h00, 8'h11, 1'b1, 3'd0, 1'b1, 1'b0);
    add(6'b000001, 8'h00, 8'h12, 1'b1, 3'd0, 1'b1, 1'b1);
    add(6'b100001, 8'h00, 8'h12, 1'b0, 3'd0, 1'b1, 1'b1);
    // build LEVEL=2 with flags still set
    add(6'b000010, 8'h60, 8'h60, 1'b1, 3'd1, 1'b1, 1'b1);
    add(6'b000010, 8'h70, 8'h70, 1'b1, 3'd2, 1'b1, 1'b1);

    // reset
    rst_n = 1'b0;
    drive(6'b100000, 8'h00);
    step();
    step();
    check("reset", 8'h00, 1'b0, 3'd0, 1'b0, 1'b0);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].ctrl, vecs[i].tgt);
      step();
      check($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_fv,
            vecs[i].e_lvl, vecs[i].e_ovf, vecs[i].e_unf);
    end

    // reset while halted, mid call chain
    rst_n = 1'b0;
    drive(6'b100000, 8'h00);
    step();
    check("mid_reset", 8'h00, 1'b0, 3'd0, 1'b0, 1'b0);
    rst_n = 1'b1;

    // ten halted cycles with JUMP asserted
    drive(6'b110000, 8'h40);
    for (int k = 0; k < 10; k++) begin
      step();
      check($sformatf("hold%0d", k), 8'h00, 1'b0, 3'd0, 1'b0, 1'b0);
    end
    drive(6'b010000, 8'h40);
    step();
    check("step_jump", 8'h40, 1'b1, 3'd0, 1'b0, 1'b0);
    drive(6'b110000, 8'h40);
    step();
    check("rehold0", 8'h40, 1'b0, 3'd0, 1'b0, 1'b0);
    step();
    check("rehold1", 8'h40, 1'b0, 3'd0, 1'b0, 1'b0);
    // stack was discarded by reset: RET underflows
    drive(6'b000001, 8'h00);
    step();
    check("post_reset_ret", 8'h41, 1'b1, 3'd0, 1'b0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
